// File: rtl/latch_bank_write_ctrl.sv
// rtl/latch_bank_write_ctrl.sv - round-robin write sequencer for a bank of transparent latches
module latch_bank_write_ctrl #(
  parameter int WIDTH     = 8,
  parameter int NUM_LATCH = 4,
  parameter int ADDR_W    = 2,
  parameter int OPEN_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [WIDTH-1:0]     data0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [WIDTH-1:0]     data1,
  output logic [1:0]           done,
  output logic                 err,
  output logic                 busy,
  output logic [NUM_LATCH-1:0] lat_en,
  output logic [WIDTH-1:0]     lat_d
);

  // OPEN lasts OPEN_CYC cycles: the counter runs from OPEN_CYC-1 down to 0.
  localparam logic [3:0] LP_OPEN_LAST = 4'(OPEN_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD} state_t;

  state_t              r_state;
  logic                r_rr;
  logic                r_gnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_cnt;

  logic                w_gnt;
  logic [ADDR_W-1:0]   w_addr;
  logic [WIDTH-1:0]    w_data;
  logic [NUM_LATCH-1:0] w_dec;
  logic                w_oor;

  // Arbitration: a lone request wins; on contention the requester not served last wins.
  always_comb begin
    w_gnt  = (req == 2'b11) ? ~r_rr : req[1];
    w_addr = w_gnt ? addr1 : addr0;
    w_data = w_gnt ? data1 : data0;
  end

  // Decode the captured address; an out-of-range address decodes to no enable at all.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NUM_LATCH; i++) begin
      w_dec[i] = (int'(r_addr) == i);
    end
    w_oor = ~|w_dec;
  end

  // Sequencer IDLE -> SETUP -> OPEN x OPEN_CYC -> HOLD -> IDLE; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b1;
      r_gnt   <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      done    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      lat_en  <= '0;
      lat_d   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= '0;
          err  <= 1'b0;
          if (|req) begin
            r_state <= S_SETUP;
            r_gnt   <= w_gnt;
            r_rr    <= w_gnt;
            r_addr  <= w_addr;
            lat_d   <= w_data;
            busy    <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_OPEN;
          r_cnt   <= LP_OPEN_LAST;
          lat_en  <= w_dec;
        end
        S_OPEN: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_HOLD;
            lat_en  <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= r_gnt ? 2'b10 : 2'b01;
          err     <= w_oor;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
